// File: rtl/freqdiv_pkg.sv
// ----------------------------------------------------------------------------
// freqdiv_pkg
// Shared constants and helpers for the programmable frequency divider.
//   - Default widths and the default terminal count (100 MHz in, 1 Hz out).
//   - bin2gray: binary to Gray conversion. It works on a GRAY_MAX_W-bit
//     vector. A caller zero-extends its field into the argument and
//     truncates the result back to the field width.
// No ports (package).
// ----------------------------------------------------------------------------
package freqdiv_pkg;

    localparam int unsigned CNT_W_DEF      = 27;
    localparam logic [26:0] DEF_DIV_DEF    = 27'd49_999_999;
    localparam int unsigned SCAN_W_DEF     = 2;
    localparam int unsigned SCAN_LSB_DEF   = 15;
    localparam int unsigned SCAN_CNT_W_DEF = 17;

    // Widest field bin2gray accepts. Wider scan fields are not expected.
    localparam int unsigned GRAY_MAX_W = 32;

    // The input is zero-extended, so the MSB of the field passes through
    // unchanged. That keeps the truncated result a valid Gray code.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/freqdiv_prog_tick_scan_counter.sv
// ----------------------------------------------------------------------------
// scan_counter
// Free-running scan counter for display multiplexing. It adds one on every
// clock, independent of the divider enable, and wraps modulo 2^SCAN_CNT_W.
// The SCAN_W-bit field starting at SCAN_LSB is registered out together with
// the counter, so it has no extra latency.
// Optional build macro FREQDIV_GRAY_SCAN_EN: the field is output Gray-coded
// (00,01,11,10 for SCAN_W=2). By default it is plain binary.
// Requires SCAN_CNT_W >= SCAN_LSB + SCAN_W.
// Ports:
//   clk         in   system clock
//   rst_p       in   asynchronous active-high reset
//   scan_ctrl_o out  registered scan select field
// ----------------------------------------------------------------------------
module scan_counter
    import freqdiv_pkg::*;
#(
    parameter int unsigned SCAN_W     = SCAN_W_DEF,
    parameter int unsigned SCAN_LSB   = SCAN_LSB_DEF,
    parameter int unsigned SCAN_CNT_W = SCAN_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_p,
    output logic [SCAN_W-1:0] scan_ctrl_o
);

    logic [SCAN_CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [SCAN_W-1:0]     scan_ctrl_q, scan_ctrl_d;
    logic [SCAN_W-1:0]     field_bin;

    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_CNT_W'(1);
        // The field is taken from the next count. The registered select then
        // lines up with the counter bits in the same cycle.
        field_bin  = scan_cnt_d[SCAN_LSB +: SCAN_W];
`ifdef FREQDIV_GRAY_SCAN_EN
        scan_ctrl_d = SCAN_W'(bin2gray(GRAY_MAX_W'(field_bin)));
`else
        scan_ctrl_d = field_bin;
`endif
    end

    // NOTE: state registers use non-blocking assignments, so every flop
    // samples its pre-edge inputs regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            scan_cnt_q  <= '0;
            scan_ctrl_q <= '0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            scan_ctrl_q <= scan_ctrl_d;
        end
    end

    assign scan_ctrl_o = scan_ctrl_q;

endmodule

// File: rtl/freqdiv_prog_tick.sv
// ----------------------------------------------------------------------------
// freqdiv_prog_tick
// Programmable clock divider with a tick strobe and a display scan field.
// The divide counter runs from 0 to active_div. At the terminal count it
// wraps, toggles clk_out and pulses tick for one cycle. The output period is
// therefore 2*(active_div+1) cycles.
// New divisors are staged in a shadow register. They take effect only at a
// terminal count, so each half-period finishes with the divisor it started
// with.
// Optional build macro FREQDIV_GRAY_SCAN_EN selects a Gray-coded scan_ctrl.
// See scan_counter.
// Ports:
//   clk        in   system clock
//   rst_p      in   asynchronous active-high reset
//   en         in   divide counter enable
//   div_load   in   one-cycle request to stage div_max
//   div_max    in   requested terminal count (CNT_W bits)
//   clk_out    out  registered 50% divided clock
//   tick       out  registered one-cycle terminal-count pulse
//   scan_ctrl  out  registered display scan select (SCAN_W bits)
// ----------------------------------------------------------------------------
module freqdiv_prog_tick
    import freqdiv_pkg::*;
#(
    parameter int unsigned      CNT_W      = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEF_DIV    = CNT_W'(DEF_DIV_DEF),
    parameter int unsigned      SCAN_W     = SCAN_W_DEF,
    parameter int unsigned      SCAN_LSB   = SCAN_LSB_DEF,
    parameter int unsigned      SCAN_CNT_W = SCAN_CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_p,
    input  logic              en,
    input  logic              div_load,
    input  logic [CNT_W-1:0]  div_max,
    output logic              clk_out,
    output logic              tick,
    output logic [SCAN_W-1:0] scan_ctrl
);

    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [CNT_W-1:0] active_div_q, active_div_d;
    logic [CNT_W-1:0] shadow_div_q, shadow_div_d;
    logic             pend_q,       pend_d;
    logic             clk_out_q,    clk_out_d;
    logic             tick_q,       tick_d;
    logic             terminal;

    // cnt never exceeds active_div. The equality compare is the only wrap
    // condition, so there is no overflow path.
    assign terminal = en && (cnt_q == active_div_q);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        cnt_d        = cnt_q;
        active_div_d = active_div_q;
        shadow_div_d = shadow_div_q;
        pend_d       = pend_q;
        clk_out_d    = clk_out_q ^ terminal;
        tick_d       = terminal;

        if (en) begin
            cnt_d = terminal ? '0 : cnt_q + CNT_W'(1);
        end

        // At a wrap, any staged divisor is applied first.
        if (terminal && pend_q) begin
            active_div_d = shadow_div_q;
            pend_d       = 1'b0;
        end

        // A load in the same cycle overwrites the shadow after the transfer
        // above. The new value then waits for the following wrap. With
        // several loads before a wrap, the last one wins.
        if (div_load) begin
            shadow_div_d = div_max;
            pend_d       = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            cnt_q        <= '0;
            active_div_q <= DEF_DIV;
            shadow_div_q <= DEF_DIV;
            pend_q       <= 1'b0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            active_div_q <= active_div_d;
            shadow_div_q <= shadow_div_d;
            pend_q       <= pend_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;

    scan_counter #(
        .SCAN_W     (SCAN_W),
        .SCAN_LSB   (SCAN_LSB),
        .SCAN_CNT_W (SCAN_CNT_W)
    ) u_scan_counter (
        .clk         (clk),
        .rst_p       (rst_p),
        .scan_ctrl_o (scan_ctrl)
    );

endmodule

// File: tb/tb_freqdiv_prog_tick.sv
module tb_freqdiv_prog_tick;

    localparam int unsigned CNT_W      = 27;
    localparam int unsigned DEF_DIV    = 3;
    localparam int unsigned SCAN_W     = 2;
    localparam int unsigned SCAN_LSB   = 2;
    localparam int unsigned SCAN_CNT_W = 8;

    logic              clk = 1'b0;
    logic              rst_p;
    logic              en;
    logic              div_load;
    logic [CNT_W-1:0]  div_max;
    logic              clk_out;
    logic              tick;
    logic [SCAN_W-1:0] scan_ctrl;

    freqdiv_prog_tick #(
        .CNT_W      (CNT_W),
        .DEF_DIV    (CNT_W'(DEF_DIV)),
        .SCAN_W     (SCAN_W),
        .SCAN_LSB   (SCAN_LSB),
        .SCAN_CNT_W (SCAN_CNT_W)
    ) dut (
        .clk       (clk),
        .rst_p     (rst_p),
        .en        (en),
        .div_load  (div_load),
        .div_max   (div_max),
        .clk_out   (clk_out),
        .tick      (tick),
        .scan_ctrl (scan_ctrl)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model, counted in enabled cycles still to go before the
    // next tick. clk_out is the parity of ticks seen so far. The scan field
    // is derived from the number of clock edges since reset.
    int m_cur;
    int m_left;
    int m_ticks;
    int m_scan;
    int m_tick;
    int m_pend[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_cur   = DEF_DIV;
        m_left  = DEF_DIV;
        m_ticks = 0;
        m_scan  = 0;
        m_tick  = 0;
        m_pend.delete();
    endtask

    task automatic model_step();
        if (rst_p) begin
            model_reset();
            return;
        end
        m_scan++;
        m_tick = (en && m_left == 0) ? 1 : 0;
        if (m_tick != 0) begin
            m_ticks++;
            if (m_pend.size() > 0) m_cur = m_pend.pop_front();
            m_left = m_cur;
        end else if (en) begin
            m_left--;
        end
        if (div_load) begin
            m_pend.delete();
            m_pend.push_back(int'(div_max));
        end
    endtask

    function automatic int exp_scan();
        int b;
        b = ((m_scan % (1 << SCAN_CNT_W)) >> SCAN_LSB) % (1 << SCAN_W);
`ifdef FREQDIV_GRAY_SCAN_EN
        b = b ^ (b >> 1);
`endif
        return b;
    endfunction

    // One clock edge: advance the model with the inputs seen at the edge,
    // then compare all outputs 1 time unit later.
    task automatic cycle(input string tag);
        @(posedge clk);
        #1;
        model_step();
        check({tag, "_tick"},    32'(tick),      32'(m_tick));
        check({tag, "_clk_out"}, 32'(clk_out),   32'(m_ticks % 2));
        check({tag, "_scan"},    32'(scan_ctrl), 32'(exp_scan()));
    endtask

    // Run until the model's count reaches target (bounded).
    task automatic wait_cnt(input int target, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (m_cur - m_left == target) begin
                found = 1'b1;
                break;
            end
            cycle(tag);
        end
        check({tag, "_reach_cnt"}, 32'(found), 32'd1);
    endtask

    // Number of edges until the next tick pulse (bounded).
    task automatic measure_gap(input string tag, output int gap);
        gap = 0;
        for (int i = 0; i < 64; i++) begin
            cycle(tag);
            gap++;
            if (tick) break;
        end
    endtask

    initial begin
        int gap;
        int highs;
        model_reset();
        rst_p    = 1'b1;
        en       = 1'b0;
        div_load = 1'b0;
        div_max  = '0;

        // Outputs stay 0 throughout reset.
        en = 1'b1;
        repeat (3) cycle("in_reset");
        rst_p = 1'b0;

        // Default divisor 3: tick every 4 cycles, clk_out period 8.
        repeat (20) cycle("default_run");
        measure_gap("default_gap", gap);
        check("default_tick_period", 32'(gap), 32'd4);

        // Freeze at cnt=2 for 10 cycles, then resume.
        wait_cnt(2, "hold_sync");
        en = 1'b0;
        repeat (10) cycle("hold_frozen");
        en = 1'b1;
        measure_gap("hold_resume", gap);
        check("hold_resume_latency", 32'(gap), 32'(m_cur - 2 + 1));

        // Reload to 1 at cnt=1: the current period still ends at 3.
        wait_cnt(1, "reload_sync");
        div_load = 1'b1;
        div_max  = CNT_W'(1);
        cycle("reload_load");
        div_load = 1'b0;
        measure_gap("reload_finish", gap);
        check("reload_old_period_done", 32'(gap), 32'd2);
        measure_gap("reload_new", gap);
        check("reload_new_period", 32'(gap), 32'd2);

        // Stage 5. On the terminal cycle, load 2: next period 6, then 3.
        wait_cnt(0, "simul_sync");
        div_load = 1'b1;
        div_max  = CNT_W'(5);
        cycle("simul_load5");
        div_load = 1'b0;
        wait_cnt(m_cur, "simul_term");
        div_load = 1'b1;
        div_max  = CNT_W'(2);
        cycle("simul_load2");
        div_load = 1'b0;
        check("simul_tick_on_wrap", 32'(tick), 32'd1);
        measure_gap("simul_p5", gap);
        check("simul_period_uses_5", 32'(gap), 32'd6);
        measure_gap("simul_p2", gap);
        check("simul_period_uses_2", 32'(gap), 32'd3);

        // div_max=0: once applied, tick every cycle and clk_out toggles.
        div_load = 1'b1;
        div_max  = '0;
        cycle("zero_load");
        div_load = 1'b0;
        measure_gap("zero_apply", gap);
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            cycle("zero_run");
            if (tick) highs++;
        end
        check("zero_tick_every_cycle", 32'(highs), 32'd8);

        // Randomised enable / load traffic against the model.
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 9) < 8);
            div_load = ($urandom_range(0, 9) == 0);
            div_max  = CNT_W'($urandom_range(0, 6));
            cycle("random");
        end
        div_load = 1'b0;
        en       = 1'b1;

        // Asynchronous reset mid-operation clears outputs at once.
        rst_p = 1'b1;
        #1;
        model_reset();
        check("async_rst_tick",    32'(tick),      32'd0);
        check("async_rst_clk_out", 32'(clk_out),   32'd0);
        check("async_rst_scan",    32'(scan_ctrl), 32'd0);
        repeat (2) cycle("async_rst_hold");
        rst_p = 1'b0;

        // Scan field steps every 4 cycles from reset.
        repeat (32) cycle("scan_seq");
        repeat (10) cycle("scan_pre_rst");
        #2;
        rst_p = 1'b1;
        #1;
        model_reset();
        check("scan_mid_rst", 32'(scan_ctrl), 32'd0);
        cycle("scan_rst_edge");
        rst_p = 1'b0;
        repeat (6) cycle("scan_after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
